// File: rtl/mem_stall_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stall_ctrl_if
// Description : Request/acknowledge port between the MEM-stage access
//               controller and a multi-cycle data memory.
//
//   mem_req    controller -> memory   request, held until acknowledged
//   mem_we     controller -> memory   1 = write, 0 = read (valid with req)
//   mem_addr   controller -> memory   word address (valid with req)
//   mem_wdata  controller -> memory   store data (valid with req)
//   mem_ack    memory -> controller   completion, one-cycle pulse
//   mem_rdata  memory -> controller   read data, valid with mem_ack
//
//   modport master : controller side
//   modport slave  : memory side
//
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stall_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface : mem_stall_ctrl_if
`default_nettype wire

// File: rtl/mem_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stall_ctrl
// Description : MEM-stage data-memory access controller for a multi-cycle
//               memory. Sits between PR3 (EX/MEM) and a req/ack memory port
//               and raises mem_stall while an access is outstanding, which
//               freezes PC/PR1/PR2/PR3 and bubbles control.
//
// Parameters
//   DATA_W   data word width
//   ADDR_W   word address width
//   TIMEOUT  max ACCESS cycles waiting for mem_ack before abort (>= 1)
//   CNT_W    timeout counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   PR3_MEM_read   in   instruction in MEM is a load
//   PR3_MEM_write  in   instruction in MEM is a store
//   PR3_addr       in   access address from PR3
//   PR3_wdata      in   store data from PR3
//   mem            --   memory port (master side of mem_stall_ctrl_if)
//   rdata_out      out  load result towards PR4 (MEM/WB)
//   mem_stall      out  freeze request to the front of the pipeline
//   timeout_err    out  sticky flag: an access was aborted on timeout
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_stall_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              PR3_MEM_read,
    input  wire logic              PR3_MEM_write,
    input  wire logic [ADDR_W-1:0] PR3_addr,
    input  wire logic [DATA_W-1:0] PR3_wdata,
    mem_stall_ctrl_if.master       mem,
    output      logic [DATA_W-1:0] rdata_out,
    output      logic              mem_stall,
    output      logic              timeout_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // The counter holds the number of ACCESS cycles already spent, so the
    // TIMEOUT-th ACCESS cycle is the one where it equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_go;
    logic              w_stall;

    assign w_go = PR3_MEM_read | PR3_MEM_write;

    // ------------------------------------------------------------------
    // State register. Reset is asynchronous so an in-flight request is
    // withdrawn the moment rst_n falls, not at the next clock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Hold everything unless a state below says otherwise.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_stall     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Stall in the same cycle the access is seen, so PR3 is
                // already frozen when the request goes out next cycle.
                w_stall   = w_go;
                w_cnt_nxt = '0;
                if (w_go) begin
                    w_state_nxt = S_ACCESS;
                    w_req_nxt   = 1'b1;
                    // A store wins when both flags are set.
                    w_we_nxt    = PR3_MEM_write;
                    w_addr_nxt  = PR3_addr;
                    w_wdata_nxt = PR3_wdata;
                end
            end

            S_ACCESS: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt + c_cnt_one;
                // The ack test comes first so an ack arriving in the last
                // allowed cycle completes normally.
                if (mem.mem_ack) begin
                    if (!r_we) begin
                        w_rdata_nxt = mem.mem_rdata;
                    end
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                end else if (r_cnt == c_cnt_last) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                end
            end

            S_DONE: begin
                // One free cycle lets the pipeline advance and PR4 capture
                // rdata_out. Whatever PR3 shows now is the instruction that
                // was just serviced, so it is not restarted.
                w_cnt_nxt   = '0;
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_cnt_nxt   = '0;
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign rdata_out     = r_rdata;
    assign timeout_err   = r_err;
    assign mem_stall     = w_stall;

endmodule : mem_stall_ctrl
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stall_ctrl
// Description : Self-checking bench for mem_stall_ctrl. A behavioural model
//               predicts, per transaction, how many cycles the request stays
//               up, which fields the memory sees, the load result and the
//               sticky error flag.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stall_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 13;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              PR3_MEM_read;
    logic              PR3_MEM_write;
    logic [ADDR_W-1:0] PR3_addr;
    logic [DATA_W-1:0] PR3_wdata;
    logic [DATA_W-1:0] rdata_out;
    logic              mem_stall;
    logic              timeout_err;

    mem_stall_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    mem_stall_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PR3_MEM_read (PR3_MEM_read),
        .PR3_MEM_write(PR3_MEM_write),
        .PR3_addr     (PR3_addr),
        .PR3_wdata    (PR3_wdata),
        .mem          (mif),
        .rdata_out    (rdata_out),
        .mem_stall    (mem_stall),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_rdata;
    bit                exp_err;

    // One MEM-stage transaction, entered and left at a negedge with the
    // DUT in IDLE. lat = ACCESS cycles before the ack (0 = ack in the first
    // request cycle); lat < 0 means the memory never answers.
    task automatic access(input bit rd, input bit wr,
                          input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] wd,
                          input int lat,
                          input logic [DATA_W-1:0] rdat,
                          input bit gap,
                          input string tag);
        bit acked;
        int ncyc;
        acked = (lat >= 0) && (lat < TIMEOUT);
        ncyc  = acked ? lat + 1 : TIMEOUT;

        PR3_MEM_read  = rd;
        PR3_MEM_write = wr;
        PR3_addr      = a;
        PR3_wdata     = wd;
        mif.mem_ack   = 1'b0;
        #1;
        n_total++;
        if ({mif.mem_req, mem_stall} !== 2'b01)
            $display("FAIL %s issue: req,stall got %b want 01", tag, {mif.mem_req, mem_stall});
        else n_pass++;
        @(negedge clk);

        for (int k = 0; k < ncyc; k++) begin
            n_total++;
            if ({mif.mem_req, mem_stall, mif.mem_we, mif.mem_addr, mif.mem_wdata} !==
                {2'b11, wr, a, wd})
                $display("FAIL %s access cyc %0d: req,stall,we,addr,wdata got %h want %h", tag, k,
                         {mif.mem_req, mem_stall, mif.mem_we, mif.mem_addr, mif.mem_wdata},
                         {2'b11, wr, a, wd});
            else n_pass++;
            // PR3 is frozen in the real pipeline; its content is don't-care here.
            PR3_MEM_read  = 1'($urandom);
            PR3_MEM_write = 1'($urandom);
            PR3_addr      = ADDR_W'($urandom);
            PR3_wdata     = DATA_W'($urandom);
            mif.mem_ack   = acked && (k == ncyc - 1);
            mif.mem_rdata = mif.mem_ack ? rdat : DATA_W'($urandom);
            @(negedge clk);
        end

        if (acked) begin
            if (!wr) exp_rdata = rdat;
        end else begin
            exp_rdata = '0;
            exp_err   = 1'b1;
        end

        // Completion cycle: stale request and a stray ack must both be ignored.
        mif.mem_ack   = 1'($urandom);
        mif.mem_rdata = DATA_W'($urandom);
        PR3_MEM_read  = 1'b1;
        PR3_MEM_write = 1'($urandom);
        #1;
        n_total++;
        if ({mif.mem_req, mem_stall, timeout_err, rdata_out} !== {2'b00, exp_err, exp_rdata})
            $display("FAIL %s done: req,stall,err,rdata got %h want %h", tag,
                     {mif.mem_req, mem_stall, timeout_err, rdata_out}, {2'b00, exp_err, exp_rdata});
        else n_pass++;
        @(negedge clk);

        PR3_MEM_read  = 1'b0;
        PR3_MEM_write = 1'b0;
        mif.mem_ack   = 1'b0;
        if (gap) begin
            mif.mem_ack = 1'($urandom);
            #1;
            n_total++;
            if ({mif.mem_req, mem_stall, timeout_err, rdata_out} !== {2'b00, exp_err, exp_rdata})
                $display("FAIL %s idle: req,stall,err,rdata got %h want %h", tag,
                         {mif.mem_req, mem_stall, timeout_err, rdata_out}, {2'b00, exp_err, exp_rdata});
            else n_pass++;
            @(negedge clk);
            mif.mem_ack = 1'b0;
            n_total++;
            if ({mif.mem_req, mem_stall, rdata_out} !== {2'b00, exp_rdata})
                $display("FAIL %s idle2: req,stall,rdata got %h want %h", tag,
                         {mif.mem_req, mem_stall, rdata_out}, {2'b00, exp_rdata});
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        PR3_MEM_read  = 1'b0;
        PR3_MEM_write = 1'b0;
        PR3_addr      = '0;
        PR3_wdata     = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        exp_rdata     = '0;
        exp_err       = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, rdata_out, mem_stall, timeout_err} !== '0)
            $display("FAIL reset: outputs got %h want 0",
                     {mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata, rdata_out, mem_stall, timeout_err});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({mif.mem_req, mem_stall, timeout_err, rdata_out} !== '0)
            $display("FAIL reset_release: req,stall,err,rdata got %h want 0",
                     {mif.mem_req, mem_stall, timeout_err, rdata_out});
        else n_pass++;
    endtask

    task automatic test_load();
        access(1'b1, 1'b0, 13'h0A5, 16'h0000, 1, 16'h1234, 1'b1, "load");
        n_total++;
        if (rdata_out !== 16'h1234)
            $display("FAIL load_result: rdata_out got %h want 1234", rdata_out);
        else n_pass++;
    endtask

    task automatic test_store();
        access(1'b0, 1'b1, 13'h010, 16'hBEEF, int'($urandom_range(0, 4)), DATA_W'($urandom), 1'b1, "store");
        n_total++;
        if (rdata_out !== 16'h1234)
            $display("FAIL store_keeps_rdata: rdata_out got %h want 1234", rdata_out);
        else n_pass++;
    endtask

    task automatic test_both();
        access(1'b1, 1'b1, ADDR_W'($urandom), DATA_W'($urandom), 0, DATA_W'($urandom), 1'b1, "both");
    endtask

    task automatic test_ack_last_cycle();
        access(1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), TIMEOUT - 1, 16'h5A5A, 1'b1, "ack_last");
        n_total++;
        if ({timeout_err, rdata_out} !== {1'b0, 16'h5A5A})
            $display("FAIL ack_last_no_err: err,rdata got %h want 05a5a", {timeout_err, rdata_out});
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            int op;
            op = int'($urandom_range(1, 3));
            access(op[0], op[1], ADDR_W'($urandom), DATA_W'($urandom),
                   int'($urandom_range(0, TIMEOUT - 1)), DATA_W'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), 2, DATA_W'($urandom), 1'b0, "b2b_first");
        access(1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), 0, DATA_W'($urandom), 1'b1, "b2b_second");
    endtask

    task automatic test_timeout();
        access(1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), -1, 16'hFFFF, 1'b1, "timeout");
        n_total++;
        if ({timeout_err, rdata_out} !== {1'b1, 16'h0000})
            $display("FAIL timeout_result: err,rdata got %h want 10000", {timeout_err, rdata_out});
        else n_pass++;
        // The flag must survive a later successful access.
        access(1'b1, 1'b0, ADDR_W'($urandom), DATA_W'($urandom), 1, DATA_W'($urandom), 1'b1, "sticky");
    endtask

    task automatic test_reset_mid_access();
        PR3_MEM_read  = 1'b1;
        PR3_MEM_write = 1'b0;
        PR3_addr      = ADDR_W'($urandom);
        @(negedge clk);
        n_total++;
        if (mif.mem_req !== 1'b1)
            $display("FAIL rst_mid_req_up: mem_req got %b want 1", mif.mem_req);
        else n_pass++;
        PR3_MEM_read = 1'b0;
        rst_n        = 1'b0;
        #1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        n_total++;
        if ({mif.mem_req, mem_stall, timeout_err, rdata_out, mif.mem_addr, mif.mem_we} !== '0)
            $display("FAIL rst_mid_async: req,stall,err,rdata,addr,we got %h want 0",
                     {mif.mem_req, mem_stall, timeout_err, rdata_out, mif.mem_addr, mif.mem_we});
        else n_pass++;
        @(negedge clk);
        rst_n         = 1'b1;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 16'hCAFE;
        @(negedge clk);
        mif.mem_ack = 1'b0;
        n_total++;
        if ({mif.mem_req, mem_stall, timeout_err, rdata_out} !== '0)
            $display("FAIL rst_late_ack: req,stall,err,rdata got %h want 0",
                     {mif.mem_req, mem_stall, timeout_err, rdata_out});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_both();
        test_ack_last_cycle();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_stall_ctrl
`default_nettype wire
